// File: rtl/timer_prescaler_mc.sv
// Multi-channel timer prescaler. Each channel divides sys_clk down to a
// count_en tick. It has a debug halt handshake and a shadowed divider config,
// so a config change restarts the prescale count cleanly.
module timer_prescaler_mc #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    dbg_mode,
  input  logic [NUM_CH-1:0]       timer_en,
  input  logic [NUM_CH-1:0]       div_en,
  input  logic [NUM_CH-1:0]       div_mode,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       halt_req,
  output logic [NUM_CH-1:0]       halt_ack,
  output logic [NUM_CH-1:0]       count_en,
  output logic [NUM_CH*CNT_W-1:0] ps_cnt
);

  localparam int unsigned CFG_W = DIV_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ch_state_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic             ack_q;
    logic [CFG_W-1:0] cfg;
    logic [DIV_W-1:0] sh_val;
    logic             sh_mode;
    logic             sh_en;
    logic [CNT_W-1:0] pow_limit;
    logic [CNT_W-1:0] lin_limit;
    logic [CNT_W-1:0] limit;
    logic             hreq;
    logic             tick;

    // Live config packed in the same layout as the shadow: {div_en, div_mode, div_val}
    assign cfg     = {div_en[i], div_mode[i], div_val[i*DIV_W +: DIV_W]};
    assign sh_val  = shadow_q[DIV_W-1:0];
    assign sh_mode = shadow_q[DIV_W];
    assign sh_en   = shadow_q[DIV_W+1];
    assign hreq    = dbg_mode & halt_req[i];

    // Shifting all-ones past the counter width yields zero, so the
    // inverted mask saturates to all-ones without an explicit compare.
    assign pow_limit = ~({CNT_W{1'b1}} << sh_val);

    if (DIV_W > CNT_W) begin : g_lin_sat
      assign lin_limit = (|sh_val[DIV_W-1:CNT_W]) ? '1 : sh_val[CNT_W-1:0];
    end else begin : g_lin_ext
      assign lin_limit = CNT_W'(sh_val);
    end

    assign limit = sh_mode ? lin_limit : pow_limit;

    // State, prescale counter, config shadow and halt acknowledge registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        shadow_q <= '0;
        ack_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        shadow_q <= shadow_d;
        ack_q    <= (state_d == ST_HALT);
      end
    end

    // Next-state, counter update and combinational count_en tick
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      tick     = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d    = '0;
          shadow_d = cfg;
          if (timer_en[i]) state_d = ST_RUN;
        end
        ST_RUN: begin
          shadow_d = cfg;
          if (hreq) begin
            state_d = ST_HALT;
          end else if (!timer_en[i]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cfg != shadow_q) begin
            // Config moved under us: restart the count, new limit applies next cycle
            cnt_d = '0;
          end else if (!sh_en) begin
            tick  = 1'b1;
            cnt_d = '0;
          end else if (cnt_q == limit) begin
            tick  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HALT: begin
          if (!hreq) begin
            if (timer_en[i]) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign count_en[i]                = tick;
    assign halt_ack[i]                = ack_q;
    assign ps_cnt[i*CNT_W +: CNT_W]   = cnt_q;
  end

endmodule

// File: tb/tb_timer_prescaler_mc.sv
// Directed self-checking bench for timer_prescaler_mc (4 channels, 8-bit counters).
module tb_timer_prescaler_mc;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DIV_W  = 4;
  localparam int unsigned CNT_W  = 8;

  logic                    sys_clk;
  logic                    sys_rst_n;
  logic                    dbg_mode;
  logic [NUM_CH-1:0]       timer_en;
  logic [NUM_CH-1:0]       div_en;
  logic [NUM_CH-1:0]       div_mode;
  logic [NUM_CH*DIV_W-1:0] div_val;
  logic [NUM_CH-1:0]       halt_req;
  logic [NUM_CH-1:0]       halt_ack;
  logic [NUM_CH-1:0]       count_en;
  logic [NUM_CH*CNT_W-1:0] ps_cnt;

  int tests = 0;
  int fails = 0;

  timer_prescaler_mc #(
    .NUM_CH(NUM_CH),
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .dbg_mode (dbg_mode),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_mode (div_mode),
    .div_val  (div_val),
    .halt_req (halt_req),
    .halt_ack (halt_ack),
    .count_en (count_en),
    .ps_cnt   (ps_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] ps(input int ch);
    return 32'(ps_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    dbg_mode  = 1'b0;
    timer_en  = '0;
    div_en    = '0;
    div_mode  = '0;
    div_val   = '0;
    halt_req  = '0;

    // Reset state
    repeat (2) @(posedge sys_clk);
    #2;
    chk("rst halt_ack", 32'(halt_ack), 0);
    chk("rst count_en", 32'(count_en), 0);
    chk("rst ps_cnt", ps_cnt, 0);
    sys_rst_n = 1'b1;

    // ch0 mode0 val2 (limit 3), ch1 mode1 val4 (limit 4), ch2 undivided, ch3 off
    div_en         = 4'b0011;
    div_mode       = 4'b0010;
    div_val[3:0]   = 4'd2;
    div_val[7:4]   = 4'd4;
    timer_en       = 4'b0111;
    #1;
    chk("idle count_en", 32'(count_en), 0);
    tick();

    for (int k = 0; k < 20; k++) begin
      chk("main ps0", ps(0), 32'(k % 4));
      chk("main ce0", 32'(count_en[0]), 32'(k % 4 == 3));
      chk("main ps1", ps(1), 32'(k % 5));
      chk("main ce1", 32'(count_en[1]), 32'(k % 5 == 4));
      chk("main ce2", 32'(count_en[2]), 1);
      chk("main ps2", ps(2), 0);
      chk("main ce3", 32'(count_en[3]), 0);
      tick();
    end
    tick();
    tick();

    // Halt ch0 at ps_cnt = 2
    dbg_mode = 1'b1;
    halt_req = 4'b0001;
    #1;
    chk("hreq ps0", ps(0), 2);
    chk("hreq ce0", 32'(count_en[0]), 0);
    chk("hreq ack0 early", 32'(halt_ack[0]), 0);
    tick();
    chk("halt ack0", 32'(halt_ack[0]), 1);
    chk("halt ps0", ps(0), 2);
    chk("halt ce0", 32'(count_en[0]), 0);
    chk("halt ps1 indep", ps(1), 3);
    tick();
    chk("halt2 ps0", ps(0), 2);
    chk("halt2 ps1", ps(1), 4);
    chk("halt2 ce1", 32'(count_en[1]), 1);
    chk("halt2 ack1", 32'(halt_ack[1]), 0);
    halt_req = 4'b0000;
    #1;
    chk("release ack0 still", 32'(halt_ack[0]), 1);
    tick();
    chk("resume ack0", 32'(halt_ack[0]), 0);
    chk("resume ps0", ps(0), 2);
    chk("resume ce0", 32'(count_en[0]), 0);
    tick();
    chk("resume ps0 3", ps(0), 3);
    chk("resume ce0 3", 32'(count_en[0]), 1);
    tick();
    chk("wrap ps0", ps(0), 0);

    // Widen ch0 to limit 7, then shrink at ps_cnt = 5
    div_val[3:0] = 4'd3;
    #1;
    chk("cfg3 ce0", 32'(count_en[0]), 0);
    repeat (6) tick();
    chk("cfg3 ps0 5", ps(0), 5);
    div_val[3:0] = 4'd1;
    #1;
    chk("cfgchg ce0", 32'(count_en[0]), 0);
    tick();
    chk("cfg1 ps0 K", ps(0), 0);
    chk("cfg1 ce0 K", 32'(count_en[0]), 0);
    tick();
    chk("cfg1 ps0 L", ps(0), 1);
    chk("cfg1 ce0 L", 32'(count_en[0]), 1);
    tick();
    chk("cfg1 ps0 M", ps(0), 0);
    tick();
    chk("cfg1 ps0 N", ps(0), 1);

    // Halt at terminal count: halt takes priority over the pulse
    halt_req = 4'b0001;
    #1;
    chk("hreq prio ce0", 32'(count_en[0]), 0);
    tick();
    chk("halt B ack0", 32'(halt_ack[0]), 1);
    chk("halt B ps0", ps(0), 1);
    // Config change while halted, then release
    div_val[3:0] = 4'd2;
    halt_req     = 4'b0000;
    #1;
    chk("halt B ce0", 32'(count_en[0]), 0);
    tick();
    chk("exit ack0", 32'(halt_ack[0]), 0);
    chk("exit ps0", ps(0), 1);
    chk("exit ce0 cfgchg", 32'(count_en[0]), 0);
    tick();
    chk("exit ps0 cleared", ps(0), 0);
    repeat (3) tick();
    chk("exit ps0 3", ps(0), 3);
    chk("exit ce0 3", 32'(count_en[0]), 1);

    // ch1 linear limit 0: tick every RUN cycle after the change cycle
    div_val[7:4] = 4'd0;
    #1;
    chk("lim0 chg ce1", 32'(count_en[1]), 0);
    tick();
    chk("lim0 ce1 a", 32'(count_en[1]), 1);
    chk("lim0 ps1 a", ps(1), 0);
    tick();
    chk("lim0 ce1 b", 32'(count_en[1]), 1);

    // ch2 timer disable
    timer_en[2] = 1'b0;
    #1;
    chk("ten0 ce2", 32'(count_en[2]), 0);
    tick();
    chk("idle2 ce2", 32'(count_en[2]), 0);
    chk("idle2 ps2", ps(2), 0);

    // ch3 mode0 div_val 15 saturates to 255 on an 8-bit counter
    div_en[3]      = 1'b1;
    div_val[15:12] = 4'd15;
    timer_en[3]    = 1'b1;
    #1;
    chk("sat idle ce3", 32'(count_en[3]), 0);
    tick();
    chk("sat ps3 0", ps(3), 0);
    repeat (254) tick();
    chk("sat ps3 254", ps(3), 254);
    chk("sat ce3 254", 32'(count_en[3]), 0);
    tick();
    chk("sat ps3 255", ps(3), 255);
    chk("sat ce3 255", 32'(count_en[3]), 1);
    tick();
    chk("sat ps3 wrap", ps(3), 0);
    chk("sat ce3 wrap", 32'(count_en[3]), 0);

    // Asynchronous reset while ch0 is halted
    halt_req = 4'b0001;
    tick();
    chk("pre-rst ack0", 32'(halt_ack[0]), 1);
    chk("pre-rst ce0", 32'(count_en[0]), 0);
    sys_rst_n = 1'b0;
    #1;
    chk("async rst halt_ack", 32'(halt_ack), 0);
    chk("async rst ps_cnt", ps_cnt, 0);
    chk("async rst count_en", 32'(count_en), 0);
    halt_req = 4'b0000;
    tick();
    sys_rst_n = 1'b1;
    #1;
    chk("post-rst idle ce", 32'(count_en), 0);
    tick();
    chk("restart ps0", ps(0), 0);
    chk("restart ce0", 32'(count_en[0]), 0);
    chk("restart ack0", 32'(halt_ack[0]), 0);
    chk("restart ce1", 32'(count_en[1]), 1);
    chk("restart ce2", 32'(count_en[2]), 0);
    repeat (3) tick();
    chk("restart ps0 3", ps(0), 3);
    chk("restart ce0 3", 32'(count_en[0]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_prescaler_mc.md
TIMER_PRESCALER_MC -- requirements
Module: timer_prescaler_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent prescaler channels (1..16).
REQ-002 Parameter DIV_W, default 4, width of each channel's div_val field.
REQ-003 Parameter CNT_W, default 16, width of each channel's prescale counter (2..32).
REQ-004 sys_clk  input  1  system clock; all state on rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 dbg_mode  input  1  debug mode; global qualifier for halt requests.
REQ-007 timer_en  input  NUM_CH  per-channel timer enable.
REQ-008 div_en  input  NUM_CH  per-channel divider enable; 0 = count every cycle.
REQ-009 div_mode  input  NUM_CH  per-channel divide mode; 0 = power-of-two, 1 = linear.
REQ-010 div_val  input  NUM_CH*DIV_W  per-channel divide value; channel i in bits [i*DIV_W +: DIV_W].
REQ-011 halt_req  input  NUM_CH  per-channel halt request.
REQ-012 halt_ack  output  NUM_CH  per-channel registered halt acknowledge.
REQ-013 count_en  output  NUM_CH  per-channel count-enable tick to the main counter.
REQ-014 ps_cnt  output  NUM_CH*CNT_W  per-channel prescale counter value, packed like div_val.

Function
REQ-015 Each channel SHALL be a fully independent instance of the behaviour below; channels share only clock, reset and dbg_mode.
REQ-016 limit SHALL be 2^div_val - 1 in mode 0, saturating to 2^CNT_W - 1 when div_val >= CNT_W.
REQ-017 limit SHALL be div_val (divide by div_val+1) in mode 1, zero-extended or saturated to CNT_W bits.
REQ-018 Each channel SHALL run a 3-state FSM: IDLE, RUN, HALT.
REQ-019 IDLE: ps_cnt = 0, count_en = 0; timer_en = 1 SHALL move to RUN next cycle.
REQ-020 RUN: hreq = dbg_mode & halt_req[i]; hreq = 1 SHALL move to HALT, else timer_en = 0 SHALL move to IDLE and clear ps_cnt; hreq has priority.
REQ-021 HALT: ps_cnt SHALL hold; timer_en changes SHALL be ignored; hreq = 0 SHALL exit to RUN if timer_en = 1, else to IDLE (ps_cnt cleared).
REQ-022 halt_ack SHALL be 1 exactly while state = HALT, i.e. one cycle after hreq is first sampled in RUN; it SHALL drop the cycle after hreq deasserts.
REQ-023 In RUN with hreq = 0 and div_en = 0: count_en = 1 every cycle, ps_cnt held at 0.
REQ-024 In RUN with hreq = 0 and div_en = 1: ps_cnt == limit SHALL drive count_en = 1 (combinational, same cycle) and wrap ps_cnt to 0; otherwise ps_cnt increments by 1 and count_en = 0.
REQ-025 limit = 0 with div_en = 1 SHALL give count_en = 1 every RUN cycle.
REQ-026 count_en SHALL be 0 in IDLE and HALT, and in any RUN cycle with hreq = 1 or timer_en = 0.
REQ-027 Each channel SHALL register a shadow copy of {div_en, div_mode, div_val}; the shadow updates every cycle in IDLE and RUN and holds in HALT.
REQ-028 In RUN, input config != shadow SHALL clear ps_cnt to 0 and force count_en = 0 that cycle; counting resumes next cycle with the new limit.
REQ-029 A config change made during HALT SHALL therefore be detected and applied (REQ-028) on the first RUN cycle after exit.
REQ-030 ps_cnt SHALL never exceed limit by more than the one cycle in which a config change is detected.

Reset
REQ-031 sys_rst_n low SHALL immediately force all channels to IDLE, ps_cnt = 0, halt_ack = 0, count_en = 0, shadows = 0.
REQ-032 Reset asserted mid-count or mid-HALT SHALL abort with no count_en pulse; after release each channel starts from IDLE.

Verification
REQ-033 NUM_CH=4, ch0 mode0 div_val=2, div_en=1, timer_en=1 -> count_en[0] pulses every 4th cycle, ps_cnt 0,1,2,3,0.
REQ-034 ch1 mode1 div_val=4 -> count_en[1] every 5 cycles; ch2 div_en=0 -> count_en[2]=1 every RUN cycle; channels do not interact.
REQ-035 dbg_mode=1, halt_req[0]=1 at ps_cnt=2 -> count_en[0]=0 immediately, halt_ack[0]=1 next cycle, ps_cnt holds 2; release -> ack drops, counting resumes at 3.
REQ-036 ch0 in RUN at ps_cnt=5, div_val changed 3->1 -> ps_cnt=0, no pulse that cycle, then pulses every 2 cycles.
REQ-037 mode0 div_val=15 with CNT_W=8 -> limit=255, pulse every 256 cycles.
REQ-038 sys_rst_n pulsed low during HALT -> halt_ack=0, ps_cnt=0 asynchronously, channel restarts from IDLE.
